// File: rtl/clause_image_loader_pkg.sv
// Shared types and constants for the clause image loader: header layout and field types.
`ifndef CLAUSE_IMAGE_LOADER_DEFS
`define CLAUSE_IMAGE_LOADER_DEFS
`define NUM_ENGINE 16
`define MAX_NODES  1024
`define MAX_PTRS   256
`endif

package clause_image_loader_pkg;

    localparam int NODE_BITS = 64;
    localparam int PTR_BITS  = 16;

    typedef logic [NODE_BITS-1:0] node_t;
    typedef logic [PTR_BITS-1:0]  ptr_t;

    localparam int HDR_NODES_LSB = 0;
    localparam int HDR_PTRS_LSB  = 16;
    localparam int HDR_FIELD_W   = 16;

    typedef struct packed {
        logic [HDR_FIELD_W-1:0] num_ptrs;
        logic [HDR_FIELD_W-1:0] num_nodes;
    } img_hdr_t;

endpackage

// File: rtl/mem_rd_port.sv
// Single-outstanding clause-memory read tracker: owns request/address and drops stale responses.
module mem_rd_port #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              rd_en,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              rd_valid
);

    logic outstanding;

    // Address only moves on a consumed response, so it is stable while mem_req waits for gnt.
    assign mem_req  = rd_en && !outstanding;
    assign rd_valid = mem_rvalid && outstanding;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= 1'b0;
            mem_addr    <= '0;
        end else begin
            if (mem_req && mem_gnt)
                outstanding <= 1'b1;
            else if (rd_valid)
                outstanding <= 1'b0;

            if (load)
                mem_addr <= base_addr;
            else if (rd_valid)
                mem_addr <= mem_addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/clause_image_loader.sv
// Walks per-engine clause images in memory and streams nodes, dummy pointers and engine
// advances into the BCP accelerator load interface.
//
//   state  | meaning
//   IDLE   | waiting for start
//   HDR    | fetching engine header, bound check
//   NODE   | fetching node words
//   PTR    | fetching dummy pointer words
//   ENG    | advance engine index, decide next engine or finish
//   FIN    | one-cycle done, back to IDLE
module clause_image_loader
    import clause_image_loader_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int WORD_W    = 64,
    parameter int NODE_W    = 64,
    parameter int PTR_W     = 16,
    parameter int MAX_NODES = `MAX_NODES,
    parameter int MAX_PTRS  = `MAX_PTRS,
    parameter int ENG_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ENG_W-1:0]  num_eng,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [NODE_W-1:0] node_out,
    output logic              node_out_valid,
    output logic [PTR_W-1:0]  dummy_ptr_out,
    output logic              dummy_ptr_valid,
    output logic              change_eng
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_NODE, S_PTR, S_ENG, S_FIN} state_t;

    localparam logic [HDR_FIELD_W-1:0] NODE_LIM = HDR_FIELD_W'(MAX_NODES);
    localparam logic [HDR_FIELD_W-1:0] PTR_LIM  = HDR_FIELD_W'(MAX_PTRS);
    localparam logic [HDR_FIELD_W-1:0] CNT_ONE  = HDR_FIELD_W'(1);

    state_t                 state, state_nxt;
    logic                   accept, rd_en, rd_valid, hdr_bad, more_eng;
    img_hdr_t               hdr;
    logic [HDR_FIELD_W-1:0] cnt_nodes, cnt_ptrs;
    logic [ENG_W-1:0]       num_eng_q, eng_idx;

    assign hdr.num_nodes = mem_rdata[HDR_NODES_LSB +: HDR_FIELD_W];
    assign hdr.num_ptrs  = mem_rdata[HDR_PTRS_LSB +: HDR_FIELD_W];
    assign hdr_bad       = (hdr.num_nodes > NODE_LIM) || (hdr.num_ptrs > PTR_LIM);
    assign more_eng      = ({1'b0, eng_idx} + {{ENG_W{1'b0}}, 1'b1}) < {1'b0, num_eng_q};

    assign accept = (state == S_IDLE) && start;
    assign rd_en  = (state == S_HDR) || (state == S_NODE) || (state == S_PTR);
    assign busy   = (state != S_IDLE) && (state != S_FIN);
    assign done   = (state == S_FIN);

    mem_rd_port #(.ADDR_W(ADDR_W)) u_rd_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept),
        .base_addr  (base_addr),
        .rd_en      (rd_en),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .rd_valid   (rd_valid)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (num_eng == '0) ? S_FIN : S_HDR;
            S_HDR: begin
                if (rd_valid) begin
                    if (hdr_bad)                  state_nxt = S_FIN;
                    else if (hdr.num_nodes != '0) state_nxt = S_NODE;
                    else if (hdr.num_ptrs != '0)  state_nxt = S_PTR;
                    else                          state_nxt = S_ENG;
                end
            end
            S_NODE: if (rd_valid && cnt_nodes == CNT_ONE)
                        state_nxt = (cnt_ptrs != '0) ? S_PTR : S_ENG;
            S_PTR:  if (rd_valid && cnt_ptrs == CNT_ONE) state_nxt = S_ENG;
            S_ENG:  state_nxt = more_eng ? S_HDR : S_FIN;
            S_FIN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // change_eng is registered so it lands in the first HDR cycle, clear of the last strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            num_eng_q       <= '0;
            eng_idx         <= '0;
            cnt_nodes       <= '0;
            cnt_ptrs        <= '0;
            error           <= 1'b0;
            node_out        <= '0;
            node_out_valid  <= 1'b0;
            dummy_ptr_out   <= '0;
            dummy_ptr_valid <= 1'b0;
            change_eng      <= 1'b0;
        end else begin
            state           <= state_nxt;
            node_out_valid  <= 1'b0;
            dummy_ptr_valid <= 1'b0;
            change_eng      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_eng_q <= num_eng;
                        eng_idx   <= '0;
                        error     <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (rd_valid) begin
                        if (hdr_bad) begin
                            error <= 1'b1;
                        end else begin
                            cnt_nodes <= hdr.num_nodes;
                            cnt_ptrs  <= hdr.num_ptrs;
                        end
                    end
                end
                S_NODE: begin
                    if (rd_valid) begin
                        node_out       <= mem_rdata[NODE_W-1:0];
                        node_out_valid <= 1'b1;
                        cnt_nodes      <= cnt_nodes - CNT_ONE;
                    end
                end
                S_PTR: begin
                    if (rd_valid) begin
                        dummy_ptr_out   <= mem_rdata[PTR_W-1:0];
                        dummy_ptr_valid <= 1'b1;
                        cnt_ptrs        <= cnt_ptrs - CNT_ONE;
                    end
                end
                S_ENG: begin
                    eng_idx    <= eng_idx + ENG_W'(1);
                    change_eng <= more_eng;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/clause_image_loader.md
Name: clause_image_loader

Overview:
- Upstream feeder of the BCP accelerator top level.
- Walks a packed per-engine clause image in clause memory through a single-outstanding read port.
- Serialises the image into the top's load interface: node_in/node_in_valid, dummy_ptr/dummy_ptr_valid and change_eng pulses.
- Sequences engine partitions 0..num_eng-1, then reports done or error to the host controller.

Parameters:
- ADDR_W, 16, clause-memory word address width.
- WORD_W, 64, memory data width; node and pointer fields taken from its LSBs.
- NODE_W, 64, width of node_t (≤ WORD_W).
- PTR_W, 16, width of ptr_t (≤ WORD_W).
- MAX_NODES, 1024, legal upper bound on nodes per engine.
- MAX_PTRS, 256, legal upper bound on dummy pointers per engine.
- ENG_W, 4, width of engine count.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to load an image; ignored while busy
- base_addr  in  ADDR_W  word address of engine 0 header; sampled on accepted start
- num_eng  in  ENG_W  number of engine partitions; sampled on accepted start; 0 → immediate done
- busy  out  1  high from accepted start until done/error cycle
- done  out  1  one-cycle pulse at end of load
- error  out  1  sticky until next accepted start; header bound violation
- mem_req  out  1  read request; held until mem_gnt
- mem_addr  out  ADDR_W  read address; stable while mem_req
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  WORD_W  read data
- node_out  out  NODE_W  to top node_in
- node_out_valid  out  1  one-cycle strobe
- dummy_ptr_out  out  PTR_W  to top dummy_ptr
- dummy_ptr_valid  out  1  one-cycle strobe
- change_eng  out  1  one-cycle pulse: advance load target to next engine

Behaviour:
- Reset (async, active-low): FSM IDLE; all outputs 0; counters and address 0. Reset mid-load aborts immediately; no done.
- Image format per engine: header word {num_ptrs[31:16], num_nodes[15:0]} in low 32 bits, then num_nodes node words, then num_ptrs pointer words. The next engine's header immediately follows at the next address.
- Address increments by 1 per word and wraps modulo 2^ADDR_W.
- One outstanding read only:
  - mem_req asserts in the state's first cycle and stays high, with mem_addr stable, until mem_gnt.
  - No new request is issued before mem_rvalid.
  - mem_rvalid while no read is outstanding is ignored, including stale responses after reset.
- States:
  - IDLE: on start, latch base_addr/num_eng, clear error, busy=1. If num_eng==0 go to FIN, else go to HDR.
  - HDR: fetch header. If num_nodes>MAX_NODES or num_ptrs>MAX_PTRS, set error and go to FIN. Otherwise load the node and pointer counters: go to NODE if num_nodes≠0, else PTR if num_ptrs≠0, else ENG.
  - NODE: fetch a word; the cycle after its mem_rvalid, node_out=rdata[NODE_W-1:0] with node_out_valid=1. Decrement the counter; at 0 go to PTR (or ENG if num_ptrs==0).
  - PTR: same as NODE, driving dummy_ptr_out/dummy_ptr_valid from rdata[PTR_W-1:0]; at 0 go to ENG.
  - ENG: increment the engine index. If it is < num_eng, pulse change_eng for one cycle and go to HDR. Otherwise go to FIN with no change_eng.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- Output timing:
  - Valid strobes are registered, exactly 1 cycle after mem_rvalid, never both in the same cycle.
  - change_eng never coincides with either valid strobe.
- No backpressure: the downstream buffer accepts every strobe.
- start asserted in the FIN cycle is ignored; it is accepted only in IDLE.
- A node count of exactly MAX_NODES is legal; MAX_NODES+1 is an error.

Decomposition:
- Shared package: node_t, ptr_t, the header field offsets, and an image-header struct type.
- Shared `define constants: NUM_ENGINE, MAX_NODES and MAX_PTRS.
- The FSM state enum stays local to the loader.
- One natural sub-module: mem_rd_port, the single-outstanding request/grant/rvalid tracker. It owns mem_req/mem_addr, the outstanding flag and stale-response dropping.

Test Plan:
- num_eng=1, header {ptrs=2,nodes=3} at 0x0010 → reads 0x0010..0x0015; 3 node_out_valid, then 2 dummy_ptr_valid; no change_eng; done 1 cycle after the last strobe; error=0.
- num_eng=3, each header {1,2} → exactly 2 change_eng pulses, each between the last ptr of engine k and the header fetch of k+1; 6 nodes and 3 ptrs total.
- Header {0,0} for engine 0 of 2 → no strobes for engine 0; change_eng pulse; engine 1 loads normally.
- mem_gnt delayed 5 cycles and rvalid latency 3 → mem_req/mem_addr stable until gnt; strobe exactly 1 cycle after each rvalid; spurious rvalid in IDLE produces no strobe.
- Header nodes=MAX_NODES+1 → error=1, done pulse, no strobes. A following start with a legal image clears error.
- rst_n low during NODE, then a late rvalid after release → all outputs 0, FSM IDLE, late rvalid ignored. base_addr=0xFFFE with 4 words → addresses wrap 0xFFFE, 0xFFFF, 0x0000, 0x0001.
